// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-beat command to APB SETUP/ACCESS initiator with wait-state timeout
module apb_cmd_master #(
    parameter int DW          = 8,
    parameter int BW          = 32,
    parameter int ADDR_W      = 16,
    parameter int STRB_W      = BW / DW,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [BW-1:0]     cmd_wdata_i,
    input  logic [STRB_W-1:0] cmd_strb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [BW-1:0]     rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [BW-1:0]     pwdata_o,
    output logic [STRB_W-1:0] pstrb_o,
    input  logic [BW-1:0]     prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Last wait-counter value before the transfer is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam bit              TO_EN   = (TIMEOUT_CYC != 0);

    state_t          state;
    logic [TO_W-1:0] wait_cnt;

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        paddr_o   <= cmd_addr_i;
                        pwrite_o  <= cmd_write_i;
                        pwdata_o  <= cmd_wdata_i;
                        pstrb_o   <= cmd_write_i ? cmd_strb_i : '0;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // pready on the expiry cycle wins over the timeout.
                    if (pready_i) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        pstrb_o       <= '0;
                        rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                        rsp_err_o     <= pslverr_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        pstrb_o       <= '0;
                        rsp_rdata_o   <= '0;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
